// File: rtl/rx_sync_detect.sv
// Bit-serial frame synchroniser: hunts a 16-bit sync word with error tolerance,
// then collects a payload, checks a trailing CRC-8 and holds the result until acked.
module rx_sync_detect #(
   parameter logic [15:0] SYNC_WORD    = 16'hD391,
   parameter int          MAX_ERR      = 0,
   parameter int          PAYLOAD_BITS = 24,
   parameter logic [7:0]  CRC_POLY     = 8'h07
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    din,
   input  logic                    bit_en,
   input  logic                    rx_mode,
   input  logic                    pkt_ack,
   output logic                    sync_det,
   output logic                    pkt_rec,
   output logic [PAYLOAD_BITS-1:0] payload,
   output logic                    crc_err,
   output logic                    ovr,
   output logic [1:0]              state_o
);

   localparam int CW = $clog2(PAYLOAD_BITS) + 1;

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] CHECK   = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   localparam logic [CW-1:0] LAST_PL  = CW'(PAYLOAD_BITS - 1);
   localparam logic [CW-1:0] LAST_CRC = CW'(7);
   localparam logic [4:0]    ERR_LIM  = 5'(MAX_ERR);

   logic [1:0]    state;
   logic [15:0]   sr;
   logic [4:0]    fill;
   logic [CW-1:0] bcnt;
   logic [7:0]    crc;

   logic [15:0]   sr_nxt;
   logic [15:0]   diff;
   logic [4:0]    err_cnt;
   logic [7:0]    crc_nxt;
   logic          match;

   assign sr_nxt  = {sr[14:0], din};
   assign diff    = sr_nxt ^ SYNC_WORD;
   assign crc_nxt = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ din}} & CRC_POLY);

   always_comb begin
      err_cnt = '0;
      for (int i = 0; i < 16; i++) err_cnt = err_cnt + 5'(diff[i]);
   end

   // fill==15 means the current strobe is the 16th fresh bit
   assign match   = (fill >= 5'd15) && (err_cnt <= ERR_LIM);
   assign state_o = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= SEARCH;
         sr       <= '0;
         fill     <= '0;
         bcnt     <= '0;
         crc      <= '0;
         payload  <= '0;
         sync_det <= 1'b0;
         pkt_rec  <= 1'b0;
         crc_err  <= 1'b0;
         ovr      <= 1'b0;
      end else begin
         sync_det <= 1'b0;
         crc_err  <= 1'b0;
         if (!rx_mode) begin
            // payload is deliberately kept; everything else returns to idle
            state   <= SEARCH;
            sr      <= '0;
            fill    <= '0;
            bcnt    <= '0;
            crc     <= '0;
            pkt_rec <= 1'b0;
            ovr     <= 1'b0;
         end else begin
            case (state)
               SEARCH: if (bit_en) begin
                  sr <= sr_nxt;
                  if (fill != 5'd16) fill <= fill + 5'd1;
                  if (match) begin
                     sync_det <= 1'b1;
                     state    <= PAYLOAD;
                     crc      <= '0;
                     bcnt     <= '0;
                  end
               end
               PAYLOAD: if (bit_en) begin
                  payload <= {payload[PAYLOAD_BITS-2:0], din};
                  crc     <= crc_nxt;
                  if (bcnt == LAST_PL) begin
                     state <= CHECK;
                     bcnt  <= '0;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
               CHECK: if (bit_en) begin
                  crc <= crc_nxt;
                  if (bcnt == LAST_CRC) begin
                     bcnt <= '0;
                     if (crc_nxt == 8'h00) begin
                        state   <= HOLD;
                        pkt_rec <= 1'b1;
                     end else begin
                        crc_err <= 1'b1;
                        state   <= SEARCH;
                        sr      <= '0;
                        fill    <= '0;
                     end
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end
               default: begin
                  // HOLD: incoming bits are lost, ack still wins
                  if (bit_en) ovr <= 1'b1;
                  if (pkt_ack) begin
                     pkt_rec <= 1'b0;
                     state   <= SEARCH;
                     sr      <= '0;
                     fill    <= '0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_sync_detect.sv
// Directed bench for rx_sync_detect: two instances (MAX_ERR=0 and MAX_ERR=1)
// share one bit stream; each task checks its own scenario inline.
module tb_rx_sync_detect;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic din = 1'b0;
   logic bit_en = 1'b0;
   logic rx_mode = 1'b0;
   logic pkt_ack = 1'b0;

   logic        sync_det0, pkt_rec0, crc_err0, ovr0;
   logic [23:0] payload0;
   logic [1:0]  state0;
   logic        sync_det1, pkt_rec1, crc_err1, ovr1;
   logic [23:0] payload1;
   logic [1:0]  state1;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_sync0 = 0, cnt_crc0 = 0, cnt_sync1 = 0;
   logic s_sync0, s_pkt0, s_crc0;
   int c0, c1, k0;

   always #5 clk = ~clk;

   rx_sync_detect u0 (
      .clk(clk), .rst(rst), .din(din), .bit_en(bit_en), .rx_mode(rx_mode), .pkt_ack(pkt_ack),
      .sync_det(sync_det0), .pkt_rec(pkt_rec0), .payload(payload0), .crc_err(crc_err0),
      .ovr(ovr0), .state_o(state0)
   );

   rx_sync_detect #(.MAX_ERR(1)) u1 (
      .clk(clk), .rst(rst), .din(din), .bit_en(bit_en), .rx_mode(rx_mode), .pkt_ack(pkt_ack),
      .sync_det(sync_det1), .pkt_rec(pkt_rec1), .payload(payload1), .crc_err(crc_err1),
      .ovr(ovr1), .state_o(state1)
   );

   always @(negedge clk) begin
      if (sync_det0) cnt_sync0 <= cnt_sync0 + 1;
      if (crc_err0)  cnt_crc0  <= cnt_crc0 + 1;
      if (sync_det1) cnt_sync1 <= cnt_sync1 + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // one strobe every 4 clocks; outputs captured one clock after the strobe edge
   task automatic send_bit(input logic b);
      @(negedge clk);
      din = b;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      s_sync0 = sync_det0;
      s_pkt0  = pkt_rec0;
      s_crc0  = crc_err0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_bits(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic restart();
      @(negedge clk) rx_mode = 1'b0;
      @(negedge clk) rx_mode = 1'b1;
   endtask

   task automatic ack();
      @(negedge clk);
      n_cmp++; if (pkt_rec0 !== 1'b1) begin n_bad++; $display("FAIL ack_pre_pkt_rec: got %b want 1", pkt_rec0); end
      pkt_ack = 1'b1;
      @(negedge clk);
      pkt_ack = 1'b0;
      n_cmp++; if (pkt_rec0 !== 1'b0) begin n_bad++; $display("FAIL ack_pkt_rec: got %b want 0", pkt_rec0); end
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL ack_state: got %0d want 0", state0); end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state0); end
      n_cmp++; if (payload0 !== 24'h0) begin n_bad++; $display("FAIL reset_payload: got %h want 0", payload0); end
      n_cmp++; if ({sync_det0, pkt_rec0, crc_err0, ovr0} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {sync_det0, pkt_rec0, crc_err0, ovr0}); end
      @(negedge clk) rst = 1'b1;
      rx_mode = 1'b1;
   endtask

   task automatic test_good_frame();
      c0 = cnt_sync0; k0 = cnt_crc0;
      send_bits(48'hD391 >> 1, 15);
      n_cmp++; if (cnt_sync0 !== c0) begin n_bad++; $display("FAIL good_early_sync: got %0d pulses want 0", cnt_sync0 - c0); end
      send_bit(1'b1);
      n_cmp++; if (s_sync0 !== 1'b1) begin n_bad++; $display("FAIL good_sync_det: got %b want 1", s_sync0); end
      n_cmp++; if (state0 !== 2'd1) begin n_bad++; $display("FAIL good_state_payload: got %0d want 1", state0); end
      send_bits(48'hA5C33C, 24);
      n_cmp++; if (state0 !== 2'd2) begin n_bad++; $display("FAIL good_state_check: got %0d want 2", state0); end
      send_bits(48'hEE >> 1, 7);
      n_cmp++; if (pkt_rec0 !== 1'b0) begin n_bad++; $display("FAIL good_pkt_early: got %b want 0", pkt_rec0); end
      send_bit(1'b0);
      n_cmp++; if (s_pkt0 !== 1'b1) begin n_bad++; $display("FAIL good_pkt_latency: got %b want 1", s_pkt0); end
      n_cmp++; if (payload0 !== 24'hA5C33C) begin n_bad++; $display("FAIL good_payload: got %h want a5c33c", payload0); end
      n_cmp++; if (state0 !== 2'd3) begin n_bad++; $display("FAIL good_state_hold: got %0d want 3", state0); end
      n_cmp++; if (cnt_crc0 !== k0) begin n_bad++; $display("FAIL good_crc_err: got %0d pulses want 0", cnt_crc0 - k0); end
      n_cmp++; if (cnt_sync0 - c0 !== 1) begin n_bad++; $display("FAIL good_sync_count: got %0d want 1", cnt_sync0 - c0); end
      ack();
   endtask

   task automatic test_bad_crc();
      restart();
      k0 = cnt_crc0;
      send_bits({16'hD391, 24'hA5C33C, 8'hEF}, 48);
      n_cmp++; if (s_crc0 !== 1'b1) begin n_bad++; $display("FAIL bad_crc_pulse: got %b want 1", s_crc0); end
      n_cmp++; if (cnt_crc0 - k0 !== 1) begin n_bad++; $display("FAIL bad_crc_count: got %0d want 1", cnt_crc0 - k0); end
      n_cmp++; if (pkt_rec0 !== 1'b0) begin n_bad++; $display("FAIL bad_crc_pkt_rec: got %b want 0", pkt_rec0); end
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL bad_crc_state: got %0d want 0", state0); end
      send_bits({16'hD391, 24'hA5C33C, 8'hEE}, 48);
      n_cmp++; if (s_pkt0 !== 1'b1) begin n_bad++; $display("FAIL bad_then_good_pkt: got %b want 1", s_pkt0); end
      n_cmp++; if (payload0 !== 24'hA5C33C) begin n_bad++; $display("FAIL bad_then_good_payload: got %h want a5c33c", payload0); end
      n_cmp++; if (cnt_crc0 - k0 !== 1) begin n_bad++; $display("FAIL bad_then_good_crc: got %0d want 1", cnt_crc0 - k0); end
      ack();
   endtask

   task automatic test_tolerance();
      restart();
      c0 = cnt_sync0; c1 = cnt_sync1;
      send_bits(48'hD390, 16);
      n_cmp++; if (cnt_sync1 - c1 !== 1) begin n_bad++; $display("FAIL tol1_sync: got %0d want 1", cnt_sync1 - c1); end
      n_cmp++; if (cnt_sync0 !== c0) begin n_bad++; $display("FAIL tol0_reject: got %0d want 0", cnt_sync0 - c0); end
      send_bits({24'hA5C33C, 8'hEE}, 32);
      n_cmp++; if (pkt_rec1 !== 1'b1) begin n_bad++; $display("FAIL tol1_pkt_rec: got %b want 1", pkt_rec1); end
      n_cmp++; if (payload1 !== 24'hA5C33C) begin n_bad++; $display("FAIL tol1_payload: got %h want a5c33c", payload1); end
      restart();
      c1 = cnt_sync1;
      send_bits(48'hD392, 16);
      n_cmp++; if (cnt_sync1 !== c1) begin n_bad++; $display("FAIL tol1_two_err: got %0d want 0", cnt_sync1 - c1); end
      n_cmp++; if (state1 !== 2'd0) begin n_bad++; $display("FAIL tol1_two_err_state: got %0d want 0", state1); end
   endtask

   task automatic test_overrun();
      restart();
      send_bits({16'hD391, 24'hA5C33C, 8'hEE}, 48);
      n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL ovr_pre: got %b want 0", ovr0); end
      send_bits(48'b101, 3);
      n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", ovr0); end
      n_cmp++; if (payload0 !== 24'hA5C33C) begin n_bad++; $display("FAIL ovr_payload: got %h want a5c33c", payload0); end
      n_cmp++; if (state0 !== 2'd3) begin n_bad++; $display("FAIL ovr_state: got %0d want 3", state0); end
      @(negedge clk);
      pkt_ack = 1'b1; bit_en = 1'b1; din = 1'b1;
      @(negedge clk);
      pkt_ack = 1'b0; bit_en = 1'b0;
      n_cmp++; if (pkt_rec0 !== 1'b0) begin n_bad++; $display("FAIL ovr_ack_pkt_rec: got %b want 0", pkt_rec0); end
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL ovr_ack_state: got %0d want 0", state0); end
      repeat (5) @(negedge clk);
      n_cmp++; if (ovr0 !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr0); end
      restart();
      n_cmp++; if (ovr0 !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", ovr0); end
   endtask

   task automatic test_rx_mode_abort();
      restart();
      c0 = cnt_sync0;
      send_bits({16'hD391, 10'b1010010111}, 26);
      n_cmp++; if (state0 !== 2'd1) begin n_bad++; $display("FAIL abort_mid_state: got %0d want 1", state0); end
      @(negedge clk) rx_mode = 1'b0;
      @(negedge clk);
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL abort_state: got %0d want 0", state0); end
      // 10 bits of a5c33c shifted onto the previously held a5c33c
      n_cmp++; if (payload0 !== 24'h0CF297) begin n_bad++; $display("FAIL abort_payload_kept: got %h want 0cf297", payload0); end
      rx_mode = 1'b1;
      send_bits({14'h033C, 8'hEE}, 22);
      n_cmp++; if (pkt_rec0 !== 1'b0) begin n_bad++; $display("FAIL abort_no_pkt: got %b want 0", pkt_rec0); end
      n_cmp++; if (cnt_sync0 - c0 !== 1) begin n_bad++; $display("FAIL abort_sync_count: got %0d want 1", cnt_sync0 - c0); end
      send_bits({16'hD391, 24'h123456, 8'hEE}, 48);
      n_cmp++; if (pkt_rec0 !== 1'b0) begin n_bad++; $display("FAIL abort_wrong_crc_pkt: got %b want 0", pkt_rec0); end
      send_bits({16'hD391, 24'hA5C33C, 8'hEE}, 48);
      n_cmp++; if (pkt_rec0 !== 1'b1) begin n_bad++; $display("FAIL abort_new_pkt: got %b want 1", pkt_rec0); end
      n_cmp++; if (payload0 !== 24'hA5C33C) begin n_bad++; $display("FAIL abort_new_payload: got %h want a5c33c", payload0); end
      ack();
   endtask

   task automatic test_sync_fill();
      restart();
      c0 = cnt_sync0;
      send_bits(48'h5A5D, 16);
      restart();
      send_bits(48'h391, 12);
      n_cmp++; if (cnt_sync0 !== c0) begin n_bad++; $display("FAIL fill_tail_sync: got %0d want 0", cnt_sync0 - c0); end
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL fill_tail_state: got %0d want 0", state0); end
      send_bits(48'hD391 >> 1, 15);
      n_cmp++; if (cnt_sync0 !== c0) begin n_bad++; $display("FAIL fill_early_sync: got %0d want 0", cnt_sync0 - c0); end
      send_bit(1'b1);
      n_cmp++; if (s_sync0 !== 1'b1) begin n_bad++; $display("FAIL fill_full_sync: got %b want 1", s_sync0); end
   endtask

   task automatic test_async_reset();
      restart();
      send_bits({16'hD391, 5'b10100}, 21);
      n_cmp++; if (state0 !== 2'd1) begin n_bad++; $display("FAIL areset_pre_state: got %0d want 1", state0); end
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (state0 !== 2'd0) begin n_bad++; $display("FAIL areset_state: got %0d want 0", state0); end
      n_cmp++; if (payload0 !== 24'h0) begin n_bad++; $display("FAIL areset_payload: got %h want 0", payload0); end
      n_cmp++; if ({sync_det0, pkt_rec0, crc_err0, ovr0} !== 4'b0) begin n_bad++; $display("FAIL areset_flags: got %b want 0000", {sync_det0, pkt_rec0, crc_err0, ovr0}); end
      @(negedge clk) rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_crc();
      test_tolerance();
      test_overrun();
      test_rx_mode_abort();
      test_sync_fill();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
